tx_polyphase_fir: RTL and testbench
===================================

# tx_polyphase_fir

Parametrised multi-channel polyphase raised-cosine TX interpolation filter. It is the next generation of the fixed 4-phase/6-tap single-channel TX FIR. Each channel takes one BPSK symbol bit per symbol period and produces N_PHASE saturated samples per symbol, generating phases with an internal counter. Coefficients are held in a run-time-writable register file. The block sits between the PRBS/symbol mapper and the DAC/channel model, with a registered two-stage pipeline and a valid strobe.

## Interface
- N_CH, 2: number of independent channels (e.g. I/Q).
- N_PHASE, 4: oversampling factor (phases per symbol), ≥2.
- N_TAPS, 6: taps per phase (symbol-spaced taps), ≥2.
- NB_COEFF, 12: signed coefficient width.
- NB_OUTPUT, 12: signed output width per channel.
- clk, input, 1: clock.
- i_rst, input, 1: reset. Synchronous, active-high; clock clk.
- i_enb, input, 1: advance one output phase this cycle.
- i_bit, input, N_CH: symbol bit per channel (0→+coef, 1→−coef). Sampled only on a symbol-load cycle.
- i_coef_we, input, 1: coefficient write strobe.
- i_coef_addr, input, clog2(N_PHASE·N_TAPS): address = phase·N_TAPS + tap.
- i_coef_data, input, NB_COEFF: signed coefficient.
- o_data, output, N_CH·NB_OUTPUT: channel c occupies bits [c·NB_OUTPUT +: NB_OUTPUT].
- o_valid, output, 1: o_data/o_phase/o_sat valid this cycle.
- o_phase, output, clog2(N_PHASE): phase index of o_data.
- o_sat, output, N_CH: per-channel saturation occurred on this output.
- o_sat_cnt, output, 16: saturation event count (present only with TXFIR_SAT_CNT_EN).

## Operation
- State: phase counter ph (0..N_PHASE−1), per-channel sample shift register sr[c] (N_TAPS bits, bit 0 newest), coefficient file coef[N_PHASE][N_TAPS].
- Cycle with i_enb=1:
  - Stage-1 product registers load prod[c][k] = sr[c][k] ? −coef[ph][k] : +coef[ph][k], using NB_COEFF+1 bits so that −(−2^(NB_COEFF−1)) is exact.
  - Tag register loads ph.
  - ph increments. At N_PHASE−1 it wraps to 0, and in that same cycle every sr[c] shifts left, taking i_bit[c] into bit 0. The product already registered this cycle uses the pre-shift sr.
- i_enb=0: ph, sr and the product registers hold.
- Stage 2 runs when stage-1 valid is set:
  - sum[c] = Σk prod[c][k], width NB_COEFF+1+clog2(N_TAPS), full precision, no truncation.
  - Saturate to NB_OUTPUT signed: if the bits above NB_OUTPUT−1 are not all equal to the sign, output 2^(NB_OUTPUT−1)−1 (positive) or −2^(NB_OUTPUT−1) (negative) and set o_sat[c]=1. Otherwise output the low NB_OUTPUT bits with o_sat[c]=0.
- Coefficient write: if i_coef_we and addr < N_PHASE·N_TAPS, coef[addr] ← i_coef_data at the clock edge. Out-of-range addresses are ignored.
- Write coinciding with i_enb: the product formed this cycle uses the old coefficient; the new value applies from the next cycle.

## Timing
- Latency: an i_enb cycle at edge t produces o_valid=1 at edge t+2. Throughput is one sample per clock under continuous i_enb.
- o_valid is a single-cycle pulse per enabled cycle. It does not depend on i_enb at t+1.
- Reset (any time, including mid-symbol or with the pipeline full):
  - ph=0, sr=0, coef=0, product/sum registers=0.
  - o_data=0, o_valid=0, o_phase=0, o_sat=0, o_sat_cnt=0 at the next edge.
  - In-flight samples are discarded.
  - Reset has priority over i_enb and i_coef_we.

## Configuration
- TXFIR_SAT_CNT_EN defined:
  - o_sat_cnt increments by 1 on each o_valid cycle where any o_sat bit is 1.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert i_rst for 2 cycles mid-stream → o_data=0, o_valid=0, o_phase=0, o_sat=0; after release the first o_valid has o_phase=0.
- Impulse path (defaults): write coef[0·6+0]=1024, all others 0; i_bit=0 constant, i_enb=1 continuous → o_phase sequence 0,1,2,3,0…; ch0 = 1024 at phase 0, 0 elsewhere, o_valid 2 cycles after the first enable.
- Sign / shift: same coefficients; drive i_bit[0]=1 for one symbol → −1024 appears at phase 0 of the following symbol; ch1 (i_bit[1]=0) stays +1024.
- Saturation: all phase-1 taps = 2047, bits 0 → ch output 2047 with o_sat=1; all bits 1 → −2048 with o_sat=1; with TXFIR_SAT_CNT_EN, o_sat_cnt increments once per saturated output.
- Most-negative coefficient: coef[phase0,tap0] = −2048, others 0, sr[0][0]=1 → product +2048 → output 2047, o_sat=1. With sr bit 0 → −2048, o_sat=0.
- Write/enable collision and gaps: write coef[0]=512 in the same cycle as a phase-0 enable → that output uses the old value, and the next phase-0 output uses 512; toggle i_enb 1-0-1 → ph and sr hold during the gap, and o_valid pulses only for enabled cycles.

Source files
------------

// File: rtl/tx_polyphase_fir.sv
// tx_polyphase_fir: multi-channel polyphase raised-cosine TX interpolator, N_PHASE saturated samples per BPSK symbol.
// Defining TXFIR_SAT_CNT_EN adds the o_sat_cnt saturation event counter port.
module tx_polyphase_fir #(
   parameter int N_CH      = 2,
   parameter int N_PHASE   = 4,
   parameter int N_TAPS    = 6,
   parameter int NB_COEFF  = 12,
   parameter int NB_OUTPUT = 12
) (
   input  logic                                 clk,
   input  logic                                 i_rst,
   input  logic                                 i_enb,
   input  logic [N_CH-1:0]                      i_bit,
   input  logic                                 i_coef_we,
   input  logic [$clog2(N_PHASE*N_TAPS)-1:0]    i_coef_addr,
   input  logic [NB_COEFF-1:0]                  i_coef_data,
   output logic [N_CH*NB_OUTPUT-1:0]            o_data,
   output logic                                 o_valid,
   output logic [$clog2(N_PHASE)-1:0]           o_phase,
   output logic [N_CH-1:0]                      o_sat
`ifdef TXFIR_SAT_CNT_EN
   ,output logic [15:0]                         o_sat_cnt
`endif
);
   localparam int NA = N_PHASE * N_TAPS;
   localparam int AW = $clog2(NA);
   localparam int PW = $clog2(N_PHASE);
   localparam int NP = NB_COEFF + 1;
   localparam int NS = NP + $clog2(N_TAPS);
   logic [PW-1:0]        ph_q, ph_d, tag_q;
   logic                 wrap, v1_q;
   logic [N_TAPS-1:0]    sr_q [N_CH];
   logic [N_TAPS-1:0]    sr_d [N_CH];
   logic [NB_COEFF-1:0]  coef_q [NA];
   logic signed [NP-1:0] prod_q [N_CH][N_TAPS];
   logic signed [NP-1:0] prod_d [N_CH][N_TAPS];
   logic signed [NS-1:0] sum_d [N_CH];
   logic [NB_OUTPUT-1:0] dat_d [N_CH];
   logic [N_CH-1:0]      sat_d;

   // phase advance, symbol shift on wrap, and sign-selected products from the pre-shift history
   always_comb begin
      wrap = ph_q == PW'(N_PHASE - 1);
      ph_d = wrap ? '0 : ph_q + PW'(1);
      for (int c = 0; c < N_CH; c++) begin
         sr_d[c] = wrap ? {sr_q[c][N_TAPS-2:0], i_bit[c]} : sr_q[c];
         for (int k = 0; k < N_TAPS; k++)
            prod_d[c][k] = sr_q[c][k] ? -NP'($signed(coef_q[AW'(int'(ph_q) * N_TAPS + k)]))
                                      :  NP'($signed(coef_q[AW'(int'(ph_q) * N_TAPS + k)]));
      end
   end

   // stage 1 registers and coefficient file; a same-cycle write only affects later products
   always_ff @(posedge clk) begin
      if (i_rst) begin
         ph_q   <= '0;
         tag_q  <= '0;
         v1_q   <= 1'b0;
         sr_q   <= '{default: '0};
         prod_q <= '{default: '0};
         coef_q <= '{default: '0};
      end else begin
         v1_q <= i_enb;
         if (i_enb) begin
            ph_q   <= ph_d;
            tag_q  <= ph_q;
            sr_q   <= sr_d;
            prod_q <= prod_d;
         end
         if (i_coef_we && int'(i_coef_addr) < NA)
            coef_q[i_coef_addr] <= i_coef_data;
      end
   end

   // full-precision tap sum, then clamp to the signed output range
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         sum_d[c] = '0;
         for (int k = 0; k < N_TAPS; k++)
            sum_d[c] = sum_d[c] + NS'(prod_q[c][k]);
         sat_d[c] = !((&sum_d[c][NS-1:NB_OUTPUT-1]) || !(|sum_d[c][NS-1:NB_OUTPUT-1]));
         dat_d[c] = !sat_d[c] ? sum_d[c][NB_OUTPUT-1:0]
                  : sum_d[c][NS-1] ? {1'b1, {(NB_OUTPUT-1){1'b0}}} : {1'b0, {(NB_OUTPUT-1){1'b1}}};
      end
   end

   // stage 2 output registers, valid pulses once per enabled stage-1 cycle
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_phase <= '0;
         o_sat   <= '0;
         o_data  <= '0;
      end else begin
         o_valid <= v1_q;
         if (v1_q) begin
            o_phase <= tag_q;
            o_sat   <= sat_d;
            for (int c = 0; c < N_CH; c++)
               o_data[c*NB_OUTPUT +: NB_OUTPUT] <= dat_d[c];
         end
      end
   end

`ifdef TXFIR_SAT_CNT_EN
   // count outputs with any saturated channel, sticking at all-ones
   always_ff @(posedge clk) begin
      if (i_rst)
         o_sat_cnt <= '0;
      else if (v1_q && |sat_d && o_sat_cnt != 16'hFFFF)
         o_sat_cnt <= o_sat_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_tx_polyphase_fir.sv
// tb_tx_polyphase_fir: scoreboard bench for tx_polyphase_fir with an integer reference model.
module tb_tx_polyphase_fir;
   localparam int NPH = 4;
   localparam int NT  = 6;
   localparam int NA  = NPH * NT;
   logic        clk = 1'b0, rst = 1'b1, enb = 1'b0, we = 1'b0;
   logic [1:0]  bit_i = '0;
   logic [4:0]  addr = '0;
   logic [11:0] wdata = '0;
   logic [23:0] data;
   logic        valid;
   logic [1:0]  phase;
   logic [1:0]  sat;
`ifdef TXFIR_SAT_CNT_EN
   logic [15:0] sat_cnt;
   int          cnt_m = 0;
`endif
   typedef struct {int d0; int d1; int ph; int s;} exp_t;
   exp_t        q[$];
   int          coef_m [NA];
   int          ph_m = 0;
   logic [5:0]  sr_m [2];
   bit          v1_m = 0, v2_m = 0;
   int          n_cmp = 0, n_err = 0;
   int          mn, mx, mn1;

   always #5 clk = ~clk;

   tx_polyphase_fir dut (
      .clk(clk), .i_rst(rst), .i_enb(enb), .i_bit(bit_i),
      .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(wdata),
      .o_data(data), .o_valid(valid), .o_phase(phase), .o_sat(sat)
`ifdef TXFIR_SAT_CNT_EN
      , .o_sat_cnt(sat_cnt)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int raw(input int c);
      int s = 0;
      for (int k = 0; k < NT; k++)
         s += sr_m[c][k] ? -coef_m[ph_m*NT+k] : coef_m[ph_m*NT+k];
      return s;
   endfunction

   function automatic int clamp(input int r);
      return r > 2047 ? 2047 : r < -2048 ? -2048 : r;
   endfunction

   function automatic int ovf(input int r);
      return (r > 2047 || r < -2048) ? 1 : 0;
   endfunction

   task automatic cyc();
      exp_t e;
      int   r0, r1;
      v2_m = v1_m;
      v1_m = enb && !rst;
      if (rst) begin
         q.delete();
         ph_m = 0;
         sr_m[0] = '0;
         sr_m[1] = '0;
         foreach (coef_m[a]) coef_m[a] = 0;
         v2_m = 0;
`ifdef TXFIR_SAT_CNT_EN
         cnt_m = 0;
`endif
      end else begin
         if (enb) begin
            r0 = raw(0);
            r1 = raw(1);
            e.d0 = clamp(r0);
            e.d1 = clamp(r1);
            e.ph = ph_m;
            e.s  = ovf(r0) + 2 * ovf(r1);
            q.push_back(e);
            if (ph_m == NPH - 1) begin
               sr_m[0] = {sr_m[0][4:0], bit_i[0]};
               sr_m[1] = {sr_m[1][4:0], bit_i[1]};
            end
            ph_m = (ph_m + 1) % NPH;
         end
         if (we && int'(addr) < NA) coef_m[addr] = int'($signed(wdata));
      end
      @(posedge clk);
      #1;
      chk("valid", int'(valid), int'(v2_m));
      if (valid && v2_m && q.size() > 0) begin
         e = q.pop_front();
         chk("ch0", $signed(data[11:0]), e.d0);
         chk("ch1", $signed(data[23:12]), e.d1);
         chk("phase", int'(phase), e.ph);
         chk("sat", int'(sat), e.s);
`ifdef TXFIR_SAT_CNT_EN
         if (e.s != 0 && cnt_m < 65535) cnt_m++;
         chk("sat_cnt", int'(sat_cnt), cnt_m);
`endif
      end
   endtask

   task automatic wr(input int a, input logic [11:0] d);
      we = 1'b1;
      addr = 5'(a);
      wdata = d;
      cyc();
      we = 1'b0;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_data"}, int'(data), 0);
      chk({tag, "_phase"}, int'(phase), 0);
      chk({tag, "_sat"}, int'(sat), 0);
   endtask

   initial begin
      repeat (2) cyc();
      rst_chk("rst0");
      rst = 1'b0;
      cyc();
      // impulse: coef[0][0]=1024, constant zero bits
      wr(0, 12'd1024);
      enb = 1'b1;
      cyc();
      chk("lat_t1", int'(valid), 0);
      cyc();
      chk("lat_t2_phase", int'(phase), 0);
      chk("lat_t2_ch0", $signed(data[11:0]), 1024);
      repeat (10) cyc();
      // one negative symbol on ch0 only
      bit_i = 2'b01;
      repeat (4) cyc();
      bit_i = 2'b00;
      mn = 0;
      mx = 0;
      repeat (12) begin
         cyc();
         if (valid && $signed(data[11:0]) < mn) mn = $signed(data[11:0]);
         if (valid && $signed(data[23:12]) > mx) mx = $signed(data[23:12]);
      end
      chk("sign_ch0", mn, -1024);
      chk("sign_ch1", mx, 1024);
      // saturation on phase 1
      enb = 1'b0;
      for (int a = 6; a < 12; a++) wr(a, 12'd2047);
      enb = 1'b1;
      mx = 0;
      repeat (12) begin
         cyc();
         if (valid && $signed(data[23:12]) > mx) mx = $signed(data[23:12]);
      end
      chk("sat_pos", mx, 2047);
      bit_i = 2'b11;
      mn = 0;
      repeat (32) begin
         cyc();
         if (valid && $signed(data[11:0]) < mn) mn = $signed(data[11:0]);
      end
      chk("sat_neg", mn, -2048);
      // reset with the pipeline full
      rst = 1'b1;
      repeat (2) cyc();
      rst_chk("rst1");
      rst = 1'b0;
      enb = 1'b0;
      // most-negative coefficient
      wr(0, 12'h800);
      bit_i = 2'b01;
      enb = 1'b1;
      mx = -5000;
      mn1 = 0;
      repeat (16) begin
         cyc();
         if (valid && $signed(data[11:0]) > mx) mx = $signed(data[11:0]);
         if (valid && $signed(data[23:12]) < mn1) mn1 = $signed(data[23:12]);
      end
      chk("mneg_ch0", mx, 2047);
      chk("mneg_ch1", mn1, -2048);
      // write colliding with a phase-0 enable, plus an out-of-range write
      bit_i = 2'b00;
      for (int i = 0; i < NPH && ph_m != 0; i++) cyc();
      wr(0, 12'd512);
      repeat (8) cyc();
      wr(30, 12'd2047);
      // enable gaps
      enb = 1'b1; cyc();
      enb = 1'b0; cyc();
      enb = 1'b1; cyc();
      enb = 1'b0; repeat (2) cyc();
      repeat (60) begin
         enb = 1'($urandom_range(0, 1));
         bit_i = 2'($urandom_range(0, 3));
         we = ($urandom_range(0, 3) == 0);
         addr = 5'($urandom_range(0, 31));
         wdata = 12'($urandom);
         cyc();
      end
      we = 1'b0;
      enb = 1'b0;
      repeat (4) cyc();
      chk("drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
